// File: rtl/word_deserializer_pkg.sv
// Shared types and helpers for the word deserializer: FSM state encoding and
// the word-counter width calculation.
package word_deserializer_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    // A single-word count still needs one counter bit.
    function automatic int cnt_width(input int word_count);
        int w;
        w = $clog2(word_count);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/word_deserializer.sv
// Assembles WORD_COUNT serial words (LSW first) into one wide result and
// presents it with valid/ready. Optional overflow_o via WORD_DESERIALIZER_OVERFLOW_EN.
module word_deserializer
    import word_deserializer_pkg::*;
#(
    parameter int WIDTH      = 17,
    parameter int WORD_COUNT = 4
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic                          en_i,
    input  logic                          word_valid_i,
    input  logic [WIDTH-1:0]              word_i,
    output logic                          word_ready_o,
    output logic [WIDTH*WORD_COUNT-1:0]   result_o,
    output logic                          result_valid_o,
    input  logic                          result_ready_i
`ifdef WORD_DESERIALIZER_OVERFLOW_EN
    ,
    output logic                          overflow_o
`endif
);

    localparam int              CW       = cnt_width(WORD_COUNT);
    localparam logic [CW-1:0]   LAST_CNT = CW'(WORD_COUNT - 1);

    state_t                        state_r;
    state_t                        state_next_s;
    logic [CW-1:0]                 cnt_r;
    logic [CW-1:0]                 cnt_next_s;
    logic [WIDTH*WORD_COUNT-1:0]   result_r;
    logic [WIDTH*WORD_COUNT-1:0]   result_next_s;
    logic                          valid_r;
    logic                          valid_next_s;
    logic                          ready_s;
    logic                          accept_s;
    logic                          handshake_s;

    // Handshake qualifiers; en_i gates both sides so a stall freezes everything.
    always_comb begin
        ready_s     = en_i && (state_r == COLLECT);
        accept_s    = word_valid_i && ready_s;
        handshake_s = valid_r && result_ready_i && en_i;
    end

    // Next-state, counter and result-slice update.
    always_comb begin
        state_next_s  = state_r;
        cnt_next_s    = cnt_r;
        result_next_s = result_r;
        valid_next_s  = valid_r;
        case (state_r)
            COLLECT: begin
                if (accept_s) begin
                    for (int i = 0; i < WORD_COUNT; i++) begin
                        if (cnt_r == CW'(i)) begin
                            result_next_s[i*WIDTH +: WIDTH] = word_i;
                        end else begin
                            result_next_s[i*WIDTH +: WIDTH] = result_r[i*WIDTH +: WIDTH];
                        end
                    end
                    // Explicit wrap keeps non-power-of-2 counts correct.
                    if (cnt_r == LAST_CNT) begin
                        cnt_next_s   = {CW{1'b0}};
                        state_next_s = HOLD;
                        valid_next_s = 1'b1;
                    end else begin
                        cnt_next_s   = cnt_r + CW'(1);
                    end
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            HOLD: begin
                if (handshake_s) begin
                    state_next_s = COLLECT;
                    valid_next_s = 1'b0;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = COLLECT;
                cnt_next_s   = {CW{1'b0}};
                valid_next_s = 1'b0;
            end
        endcase
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_r  <= COLLECT;
            cnt_r    <= {CW{1'b0}};
            result_r <= {(WIDTH*WORD_COUNT){1'b0}};
            valid_r  <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            cnt_r    <= cnt_next_s;
            result_r <= result_next_s;
            valid_r  <= valid_next_s;
        end
    end

`ifdef WORD_DESERIALIZER_OVERFLOW_EN
    logic overflow_r;

    // Sticky flag for words offered while the block could not take them.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            overflow_r <= 1'b0;
        end else if (en_i && word_valid_i && !ready_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign overflow_o = overflow_r;
`endif

    assign word_ready_o   = ready_s;
    assign result_o       = result_r;
    assign result_valid_o = valid_r;

endmodule

// File: tb/tb_word_deserializer.sv
// Directed bench for word_deserializer (WORD_COUNT=4 and WORD_COUNT=3 instances
// sharing one stimulus), checked against a queue/arithmetic model every cycle.
module tb_word_deserializer;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        en_i = 1'b1;
    logic        word_valid_i = 1'b0;
    logic [16:0] word_i = 17'h0;
    logic        result_ready_i = 1'b0;

    logic        word_ready_o;
    logic [67:0] result_o;
    logic        result_valid_o;
    logic        rdy3;
    logic [50:0] res3;
    logic        val3;
    logic        ovf4;
    logic        ovf3;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    always #5 clock_i = ~clock_i;

    word_deserializer #(.WIDTH(17), .WORD_COUNT(4)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .en_i(en_i),
        .word_valid_i(word_valid_i), .word_i(word_i), .word_ready_o(word_ready_o),
        .result_o(result_o), .result_valid_o(result_valid_o),
        .result_ready_i(result_ready_i)
`ifdef WORD_DESERIALIZER_OVERFLOW_EN
        , .overflow_o(ovf4)
`endif
    );

    word_deserializer #(.WIDTH(17), .WORD_COUNT(3)) dut3 (
        .clock_i(clock_i), .reset_i(reset_i), .en_i(en_i),
        .word_valid_i(word_valid_i), .word_i(word_i), .word_ready_o(rdy3),
        .result_o(res3), .result_valid_o(val3),
        .result_ready_i(result_ready_i)
`ifdef WORD_DESERIALIZER_OVERFLOW_EN
        , .overflow_o(ovf3)
`endif
    );

`ifndef WORD_DESERIALIZER_OVERFLOW_EN
    assign ovf4 = 1'b0;
    assign ovf3 = 1'b0;
`endif

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: instance k collects words into slot m_n[k] until wc[k] words are held.
    int          wc [2] = '{4, 3};
    logic [67:0] m_res [2];
    int          m_n [2];
    bit          m_hold [2];
    bit          m_ovf [2];
    logic [67:0] got4_q [$];
    logic [67:0] got3_q [$];

    always @(posedge clock_i) begin
        started <= 1'b1;
        for (int k = 0; k < 2; k++) begin
            bit was_hold;
            was_hold = m_hold[k];
            if (reset_i) begin
                m_res[k]  = 68'h0;
                m_n[k]    = 0;
                m_hold[k] = 1'b0;
                m_ovf[k]  = 1'b0;
            end else if (en_i) begin
                if (!was_hold && word_valid_i) begin
                    m_res[k][m_n[k]*17 +: 17] = word_i;
                    m_n[k] = m_n[k] + 1;
                    if (m_n[k] == wc[k]) begin
                        m_n[k]    = 0;
                        m_hold[k] = 1'b1;
                    end
                end
                if (was_hold && word_valid_i) m_ovf[k] = 1'b1;
                if (was_hold && result_ready_i) m_hold[k] = 1'b0;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clock_i) begin
        if (started) begin
            chk("ready4", 68'(word_ready_o), 68'(en_i && !m_hold[0]));
            chk("valid4", 68'(result_valid_o), 68'(m_hold[0]));
            chk("result4", result_o, m_res[0]);
            chk("ready3", 68'(rdy3), 68'(en_i && !m_hold[1]));
            chk("valid3", 68'(val3), 68'(m_hold[1]));
            chk("result3", 68'(res3), m_res[1] & {17'h0, {51{1'b1}}});
            chk("cnt3_bound", 68'(dut3.cnt_r <= 2'd2), 68'd1);
`ifdef WORD_DESERIALIZER_OVERFLOW_EN
            chk("ovf4", 68'(ovf4), 68'(m_ovf[0]));
            chk("ovf3", 68'(ovf3), 68'(m_ovf[1]));
`endif
            if (result_valid_o && result_ready_i && en_i) got4_q.push_back(result_o);
            if (val3 && result_ready_i && en_i) got3_q.push_back(68'(res3));
        end
    end

    task automatic cyc(input logic e, input logic v, input logic [16:0] w, input logic rr);
        en_i = e; word_valid_i = v; word_i = w; result_ready_i = rr;
        @(posedge clock_i);
        #1;
    endtask

    // Streams n words base, base+1, ...; a word advances only when accepted.
    task automatic stream(input int sel, input int n, input logic [16:0] base, output int lows);
        int   acc;
        int   cycles;
        logic r;
        acc = 0; cycles = 0; lows = 0;
        while (acc < n && cycles < 40) begin
            en_i = 1'b1; word_valid_i = 1'b1; word_i = base + 17'(acc); result_ready_i = 1'b1;
            @(negedge clock_i);
            r = (sel == 0) ? word_ready_o : rdy3;
            @(posedge clock_i);
            #1;
            if (r) acc++; else lows++;
            cycles++;
        end
        chk("stream_done", 68'(acc), 68'(n));
        word_valid_i = 1'b0;
    endtask

    initial begin
        int lows;
        reset_i = 1'b1;
        cyc(1'b1, 1'b0, 17'h0, 1'b0);
        cyc(1'b1, 1'b0, 17'h0, 1'b0);
        chk("rst_valid", 68'(result_valid_o), 68'd0);
        chk("rst_result", result_o, 68'h0);
        chk("rst_ready", 68'(word_ready_o), 68'd1);
        reset_i = 1'b0;

        // Basic assembly and handshake.
        cyc(1'b1, 1'b1, 17'h00001, 1'b1);
        cyc(1'b1, 1'b1, 17'h00002, 1'b1);
        cyc(1'b1, 1'b1, 17'h00003, 1'b1);
        chk("t1_res3", 68'(res3), 68'({17'h00003, 17'h00002, 17'h00001}));
        chk("t1_valid_early", 68'(result_valid_o), 68'd0);
        cyc(1'b1, 1'b1, 17'h1FFFF, 1'b1);
        chk("t1_valid", 68'(result_valid_o), 68'd1);
        chk("t1_result", result_o, {17'h1FFFF, 17'h00003, 17'h00002, 17'h00001});
        cyc(1'b1, 1'b0, 17'h0, 1'b1);
        chk("t1_drop", 68'(result_valid_o), 68'd0);
        chk("t1_ready", 68'(word_ready_o), 68'd1);
        chk("t1_kept", result_o, {17'h1FFFF, 17'h00003, 17'h00002, 17'h00001});
        got4_q.delete();

        // Back-to-back results with valid held high.
        stream(0, 8, 17'h00010, lows);
        chk("t2_lows", 68'(lows), 68'd1);
        chk("t2_ready_hold", 68'(word_ready_o), 68'd0);
        cyc(1'b1, 1'b0, 17'h0, 1'b1);
        chk("t2_count", 68'(got4_q.size()), 68'd2);
        if (got4_q.size() == 2) begin
            chk("t2_r0", got4_q[0], {17'h00013, 17'h00012, 17'h00011, 17'h00010});
            chk("t2_r1", got4_q[1], {17'h00017, 17'h00016, 17'h00015, 17'h00014});
        end else begin
            chk("t2_r_present", 68'(got4_q.size()), 68'd2);
        end

        // Enable stalls in COLLECT and HOLD.
        reset_i = 1'b1; cyc(1'b1, 1'b0, 17'h0, 1'b0); reset_i = 1'b0;
        cyc(1'b1, 1'b1, 17'h000A1, 1'b0);
        cyc(1'b1, 1'b1, 17'h000A2, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 17'h000A3, 1'b1);
        chk("t3_partial", result_o, {34'h0, 17'h000A2, 17'h000A1});
        cyc(1'b1, 1'b1, 17'h000A3, 1'b0);
        chk("t3_not_yet", 68'(result_valid_o), 68'd0);
        cyc(1'b1, 1'b1, 17'h000A4, 1'b0);
        chk("t3_done", 68'(result_valid_o), 68'd1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 17'h0, 1'b1);
        chk("t3_hold_valid", 68'(result_valid_o), 68'd1);
`ifdef WORD_DESERIALIZER_OVERFLOW_EN
        chk("t3_no_ovf", 68'(ovf4), 68'd0);
`endif
        cyc(1'b1, 1'b0, 17'h0, 1'b1);
        chk("t3_hs", 68'(result_valid_o), 68'd0);
        chk("t3_result", result_o, {17'h000A4, 17'h000A3, 17'h000A2, 17'h000A1});

        // Reset mid-collection, then refill.
        cyc(1'b1, 1'b1, 17'h0AAAA, 1'b0);
        cyc(1'b1, 1'b1, 17'h15555, 1'b0);
        reset_i = 1'b1; cyc(1'b1, 1'b1, 17'h1EEEE, 1'b0); reset_i = 1'b0;
        chk("t4_zeroed", result_o, 68'h0);
        cyc(1'b1, 1'b1, 17'h00C01, 1'b0);
        chk("t4_slice0", result_o, {51'h0, 17'h00C01});
        cyc(1'b1, 1'b1, 17'h00C02, 1'b0);
        cyc(1'b1, 1'b1, 17'h00C03, 1'b0);
        cyc(1'b1, 1'b1, 17'h00C04, 1'b0);
        chk("t4_result", result_o, {17'h00C04, 17'h00C03, 17'h00C02, 17'h00C01});

        // Downstream back-pressure while words keep arriving.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 17'h1DEAD, 1'b0);
            chk("t5_stable", result_o, {17'h00C04, 17'h00C03, 17'h00C02, 17'h00C01});
`ifdef WORD_DESERIALIZER_OVERFLOW_EN
            chk("t5_ovf", 68'(ovf4), 68'd1);
`endif
        end
        cyc(1'b1, 1'b0, 17'h0, 1'b1);
        chk("t5_hs", 68'(result_valid_o), 68'd0);
`ifdef WORD_DESERIALIZER_OVERFLOW_EN
        chk("t5_ovf_sticky", 68'(ovf4), 68'd1);
`endif
        reset_i = 1'b1; cyc(1'b1, 1'b0, 17'h0, 1'b0); reset_i = 1'b0;
`ifdef WORD_DESERIALIZER_OVERFLOW_EN
        chk("t5_ovf_clr", 68'(ovf4), 68'd0);
`endif

        // Three-word instance: six words give two results.
        got3_q.delete();
        stream(1, 6, 17'h00020, lows);
        chk("t6_lows", 68'(lows), 68'd1);
        cyc(1'b1, 1'b0, 17'h0, 1'b1);
        chk("t6_count", 68'(got3_q.size()), 68'd2);
        if (got3_q.size() == 2) begin
            chk("t6_r0", got3_q[0], 68'({17'h00022, 17'h00021, 17'h00020}));
            chk("t6_r1", got3_q[1], 68'({17'h00025, 17'h00024, 17'h00023}));
        end else begin
            chk("t6_r_present", 68'(got3_q.size()), 68'd2);
        end

        cyc(1'b1, 1'b0, 17'h0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/word_deserializer.md
Name: word_deserializer

Overview:
Collects a serial stream of WIDTH-bit words, as produced least-significant word first by the FIOS DSP chain, and assembles WORD_COUNT words into one wide result register. It sits at the output end of the multiplier datapath, the counterpart of the input-side word skewing. It presents the assembled result downstream with a valid/ready handshake. The stream side has a valid/ready handshake and a global enable, matching the datapath stall convention.

Parameters:
WIDTH, 17, bits per word
WORD_COUNT, 4, words per assembled result (>= 2)

Ports:
clock_i  input  1  system clock, rising edge
reset_i  input  1  synchronous, active-high reset
en_i  input  1  global enable; low freezes all state
word_valid_i  input  1  word_i carries a valid word
word_i  input  WIDTH  incoming word, LSW first
word_ready_o  output  1  block can accept a word this cycle
result_o  output  WIDTH*WORD_COUNT  assembled result
result_valid_o  output  1  result_o complete and stable
result_ready_i  input  1  downstream accepts result

Behaviour:
- Clocking and reset: one clock (clock_i). Reset is synchronous and active-high (reset_i).
- Reset values: state=COLLECT, word counter cnt=0, result_o=0, result_valid_o=0. word_ready_o follows en_i after reset.
- States:
  - COLLECT: accepting words.
  - HOLD: result presented downstream.
- word_ready_o = en_i && (state==COLLECT). This is combinational.
- Word accept: word_valid_i && word_ready_o.
  - The accepted word is written to result_o[cnt*WIDTH +: WIDTH]. Other slices are unchanged.
  - cnt increments by 1.
- COLLECT->HOLD: the accept with cnt==WORD_COUNT-1 takes this transition.
  - result_valid_o rises the following cycle.
  - cnt wraps to 0 on the same edge.
  - Latency: the last word accepted at edge N gives result_valid_o=1 after edge N.
- HOLD: result_o and result_valid_o stay stable until handshake.
  - Handshake is result_valid_o && result_ready_i && en_i.
  - On handshake: result_valid_o=0 and state=COLLECT on the next edge. result_o retains its value; it is not cleared.
  - First word of the next result is accepted no earlier than the cycle after the handshake. Throughput is at most WORD_COUNT words per WORD_COUNT+1 cycles.
- en_i low:
  - no accept, no handshake, no state or counter change;
  - result_valid_o holds;
  - result_ready_i is ignored.
- word_valid_i while word_ready_o=0: the word is not accepted and produces no state change.
- result_ready_i in COLLECT: ignored.
- Reset mid-collection or in HOLD: returns to reset values on that edge. The partial result is discarded and result_o is zeroed.
- Counter width: $clog2(WORD_COUNT). Wrap is explicit at WORD_COUNT-1, so non-power-of-2 counts are correct.

Optional Feature:
- Macro: WORD_DESERIALIZER_OVERFLOW_EN.
- Defined: adds output overflow_o (1 bit, reset 0).
  - Sticky, set on the edge after any cycle with word_valid_i=1 and word_ready_o=0 while en_i=1.
  - Cleared only by reset_i.
  - A word offered while en_i=0 does not set it.
- Undefined: port absent; dropped words are not detected.

Decomposition:
- Package word_deserializer_pkg:
  - state enum (COLLECT, HOLD);
  - function returning counter width, max(1, $clog2(WORD_COUNT)).
- No sub-module. The counter and FSM are small and stay in one module.

Test Plan:
- WIDTH=17, WORD_COUNT=4, reset, then words 0x00001, 0x00002, 0x00003, 0x1FFFF on consecutive cycles with result_ready_i=1 -> result_valid_o=1 one cycle after the 4th accept. result_o = 0x1FFFF_00003_00002_00001 in 17-bit slices. Handshake then drops valid, and word_ready_o=1 the following cycle.
- Back-to-back results with word_valid_i held high and result_ready_i=1 -> word_ready_o low exactly one cycle per result in HOLD. No word is lost, and 8 words in give 2 results in order.
- Assert en_i=0 for 3 cycles after the 2nd word and again while in HOLD with result_ready_i=1 -> cnt, result_o and result_valid_o unchanged. Completion is delayed by exactly the stalled cycles.
- Assert reset_i after 2 of 4 words, then feed 4 new words -> result_o contains only the new 4 words. The first post-reset word lands in slice 0.
- Hold result_ready_i=0 for 5 cycles in HOLD while word_valid_i=1 -> result_o is stable and no word is accepted. With WORD_DESERIALIZER_OVERFLOW_EN defined, overflow_o=1 from the cycle after the first offered word and stays 1 until reset.
- WORD_COUNT=3 with 6 words -> two correct results; cnt wraps 2->0 and never reaches 3.
